reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
// - Successor to the fixed single-output power-on reset. Produces NUM_DOMAINS
//   independent active-low resets (core, UART, future periphs) on clk_in.
// - Adds: power-on hold, debounced external reset button, staggered
//   per-domain release, per-domain software reset pulses, reset-cause flags.
// - Sits at the SoC top, between board reset/button and every block's rst_n.
// PARAMETERS
// - NUM_DOMAINS      2          number of reset outputs, 1..8
// - POR_CYCLES       500_000    hold after rst_n/button release (10 ms @ 50 MHz)
// - DEBOUNCE_CYCLES  1_000_000  button must be stable this long (20 ms)
// - STAGGER_CYCLES   16         gap between release of domain i-1 and domain i, >=1
// - SW_PULSE_CYCLES  16         software reset pulse length, >=1
// PORTS
// - clk_in        in   1            system clock
// - rst_n         in   1            async active-low master reset (board POR)
// - ext_rst_in    in   1            async active-high button; synced and debounced
// - sw_rst_req    in   NUM_DOMAINS  1-cycle pulse requests reset of domain i
// - cause_clr     in   1            clears rst_cause to 0 (sync, 1 cycle)
// - rst_n_out     out  NUM_DOMAINS  per-domain active-low reset, registered
// - all_released  out  1            1 when every rst_n_out bit is 1
// - rst_cause     out  3            sticky: [0] POR, [1] EXT, [2] SW
// BEHAVIOUR
// - rst_n=0 (async): rst_n_out=0, all_released=0, rst_cause=3'b001,
//   state=HOLD, all counters=0, debounced button=0.
// - rst_n deassertion is clean at the input of this block; outputs are registered
//   flops on clk_in, so every output deasserts synchronously.
// - ext_rst_in: 2-FF synchronizer. The debounced level changes only after the
//   synced value has been stable and different for DEBOUNCE_CYCLES consecutive
//   cycles. Any toggle restarts the count.
// - FSM:
//   HOLD: all outputs low. cnt counts only while the debounced button is 0.
//     At cnt==POR_CYCLES-1, go to RELEASE with cnt=0 and idx=0.
//   RELEASE: on entry cycle rst_n_out[0]<=1. Each STAGGER_CYCLES later,
//     release idx+1. After releasing NUM_DOMAINS-1, go to RUN.
//   RUN: normal operation.
// - Debounced button rising edge in any state: next cycle all rst_n_out=0,
//   state=HOLD, cnt=0, rst_cause[1]<=1.
// - sw_rst_req[i] in RUN: next cycle rst_n_out[i]=0 for exactly
//   SW_PULSE_CYCLES cycles, then 1. rst_cause[2]<=1.
//   A repeat req during the pulse restarts that domain's counter.
//   Domains are independent; multiple bits in one cycle are all honoured.
//   sw_rst_req is ignored in HOLD and RELEASE.
// - Precedence in the same cycle: rst_n > button edge > sw_rst_req.
//   A button edge cancels active sw pulses.
// - cause_clr together with a new cause in the same cycle: the new cause bit is
//   set and the others are cleared.
// - all_released = &rst_n_out, registered, so it is 1 cycle after the last bit rises.
// - Counter width: $clog2(max(POR,DEBOUNCE,STAGGER,SW_PULSE)+1). No wrap:
//   counters saturate at their terminal value.
// STRUCTURE
// - Header rst_defs.vh: FSM state encodings (HOLD/RELEASE/RUN), cause bit
//   indices (CAUSE_POR=0, CAUSE_EXT=1, CAUSE_SW=2).
// - One sub-module, sync_debounce (2-FF sync + stability counter, param
//   DEBOUNCE_CYCLES), reused later for GPIO inputs.
// - Per-domain sw pulse counters go in a generate loop.
// - Expected size: roughly 200 lines of RTL.
// TESTING (bench params: N=3, POR=20, DEB=8, STAG=4, SW=5)
// - POR: release rst_n at t0. Domain 0 rises at t0+20±1, domain 1 at +4,
//   domain 2 at +8. all_released 1 cycle after. rst_cause=001.
// - Bounce: ext_rst_in glitches 1 cycle high every 5 cycles. No reset ever.
//   Steady 8+2 cycles high: all outputs 0, rst_cause[1]=1. Hold 30 more
//   cycles, release, then the sequence restarts 20 cycles after the debounced fall.
// - SW: in RUN, pulse sw_rst_req=3'b010. Only rst_n_out[1] is low for exactly
//   5 cycles. all_released drops. rst_cause=101.
// - SW restart: repeat req[1] on the 3rd low cycle. Low lasts 2+5 cycles total.
// - Collision: sw_rst_req=3'b111 in the same cycle as a debounced edge.
//   All low, state HOLD, no SW pulse counters remain afterward.
// - Mid-release async reset: drop rst_n while domain 1 is still in reset. All
//   outputs go 0 the same cycle (before clk). rst_cause=001. Clean re-sequence.
//   cause_clr pulse after that gives rst_cause=000.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the reset sequencer and its input conditioner:
//   state_t      - sequencer FSM encoding (HOLD / RELEASE / RUN)
//   CAUSE_*      - bit positions inside the sticky rst_cause vector
//   max4()       - largest of four cycle counts (sizes the shared counter)
//   cnt_width()  - bits needed to hold 0..max_val
// ---------------------------------------------------------------------------
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   localparam int CAUSE_W   = 3;
   localparam int CAUSE_POR = 0;
   localparam int CAUSE_EXT = 1;
   localparam int CAUSE_SW  = 2;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// ---------------------------------------------------------------------------
// reset_sequencer_sync_debounce
// Two-flop synchronizer followed by a stability filter. The filtered level
// only follows the synchronized input once the two have disagreed for
// DEBOUNCE_CYCLES consecutive cycles; any return to the current level in
// between restarts the count. Written to be reusable for GPIO inputs.
// Ports:
//   clk_in    in   sampling clock
//   rst_n     in   async active-low reset (level and rise clear to 0)
//   async_in  in   raw asynchronous input
//   level     out  debounced level, registered
//   rise      out  1-cycle pulse, high in the first cycle level reads 1
// ---------------------------------------------------------------------------
module reset_sequencer_sync_debounce
   import reset_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise
);

   localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic             sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         meta <= async_in;
         sync <= meta;
         rise <= 1'b0;
         if (sync == level) begin
            // agreement (or a bounce back) discards any partial count
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // counter resets on the flip, so it never passes its terminal value
            cnt   <= '0;
            level <= sync;
            rise  <= sync;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Generates NUM_DOMAINS independent active-low resets from a board reset and
// a debounced reset button. After reset (or button release) every domain is
// held for POR_CYCLES, then domains are released one by one STAGGER_CYCLES
// apart. In RUN each domain can be pulsed into reset by software for
// SW_PULSE_CYCLES. rst_cause records sticky POR / EXT / SW flags.
// Ports:
//   clk_in        in   system clock
//   rst_n         in   async active-low master reset
//   ext_rst_in    in   async active-high reset button (synced + debounced)
//   sw_rst_req    in   per-domain 1-cycle software reset request
//   cause_clr     in   clears rst_cause (a cause arriving the same cycle wins)
//   rst_n_out     out  per-domain active-low reset, registered
//   all_released  out  registered AND of rst_n_out (one cycle behind)
//   rst_cause     out  sticky flags [0] POR, [1] EXT, [2] SW
// ---------------------------------------------------------------------------
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_DOMAINS     = 2,
   parameter int POR_CYCLES      = 500_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int STAGGER_CYCLES  = 16,
   parameter int SW_PULSE_CYCLES = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_n,
   input  logic                   ext_rst_in,
   input  logic [NUM_DOMAINS-1:0] sw_rst_req,
   input  logic                   cause_clr,
   output logic [NUM_DOMAINS-1:0] rst_n_out,
   output logic                   all_released,
   output logic [CAUSE_W-1:0]     rst_cause
);

   // One counter width covers every timed interval in the block.
   localparam int CNT_W = cnt_width(max4(POR_CYCLES, DEBOUNCE_CYCLES,
                                         STAGGER_CYCLES, SW_PULSE_CYCLES));
   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_PULSE_CYCLES - 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       idx;
   logic                   btn_level;
   logic                   btn_rise;
   logic [NUM_DOMAINS-1:0] rel_mask;
   logic [NUM_DOMAINS-1:0] sw_take;
   logic [NUM_DOMAINS-1:0] sw_busy_nxt;
   logic [CAUSE_W-1:0]     cause_nxt;

   // ---------------------------------------------------------------- button
   reset_sequencer_sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .async_in (ext_rst_in),
      .level    (btn_level),
      .rise     (btn_rise)
   );

   // ------------------------------------------------------ software pulses
   // Requests are honoured only in RUN, and a button edge in the same cycle
   // wins over them.
   assign sw_take = sw_rst_req & {NUM_DOMAINS{(state == ST_RUN) && !btn_rise}};

   for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_sw
      logic             busy;
      logic [CNT_W-1:0] pcnt;

      // low next cycle if newly requested or still short of the pulse end
      assign sw_busy_nxt[g] = sw_take[g] | (busy & (pcnt != SW_LAST));

      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            busy <= 1'b0;
            pcnt <= '0;
         end else if (btn_rise) begin
            busy <= 1'b0;
            pcnt <= '0;
         end else if (sw_take[g]) begin
            // a repeat request restarts the pulse from the beginning
            busy <= 1'b1;
            pcnt <= '0;
         end else if (busy) begin
            if (pcnt == SW_LAST) begin
               busy <= 1'b0;
               pcnt <= '0;
            end else begin
               pcnt <= pcnt + CNT_W'(1);
            end
         end
      end
   end

   // ----------------------------------------------------------- sequencing
   // Domains 0..idx+1 released: the pattern after the next stagger step.
   always_comb begin
      rel_mask = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         rel_mask[i] = (i <= int'(idx) + 1);
      end
   end

   always_comb begin
      cause_nxt = cause_clr ? '0 : rst_cause;
      if (btn_rise)  cause_nxt[CAUSE_EXT] = 1'b1;
      if (|sw_take)  cause_nxt[CAUSE_SW]  = 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_HOLD;
         cnt          <= '0;
         idx          <= '0;
         rst_n_out    <= '0;
         all_released <= 1'b0;
         rst_cause    <= CAUSE_W'(1) << CAUSE_POR;
      end else begin
         all_released <= &rst_n_out;
         rst_cause    <= cause_nxt;
         if (btn_rise) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            idx       <= '0;
            rst_n_out <= '0;
         end else begin
            unique case (state)
               ST_HOLD: begin
                  rst_n_out <= '0;
                  // a held button freezes the hold count at zero
                  if (!btn_level) begin
                     if (cnt == POR_LAST) begin
                        cnt          <= '0;
                        idx          <= '0;
                        rst_n_out[0] <= 1'b1;
                        state        <= (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               end
               ST_RELEASE: begin
                  if (cnt == STAG_LAST) begin
                     cnt       <= '0;
                     idx       <= idx + IDX_W'(1);
                     rst_n_out <= rel_mask;
                     if (int'(idx) + 1 >= NUM_DOMAINS - 1) state <= ST_RUN;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               ST_RUN: begin
                  rst_n_out <= ~sw_busy_nxt;
               end
               default: begin
                  state     <= ST_HOLD;
                  cnt       <= '0;
                  rst_n_out <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Scenario tasks queue timed expectations (cycle, rst_n_out, all_released,
// rst_cause) as they plan stimulus, then step the clock and compare each
// entry when its cycle comes round. Timing in the comments is in clock
// edges counted from the moment the stimulus is applied.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

   localparam int N    = 3;
   localparam int POR  = 20;
   localparam int DEB  = 8;
   localparam int STAG = 4;
   localparam int SW   = 5;

   typedef struct {
      int         cyc;
      logic [2:0] out;
      logic       al;
      logic [2:0] cause;
      string      name;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ext_rst_in;
   logic [N-1:0] sw_rst_req;
   logic         cause_clr;
   logic [N-1:0] rst_n_out;
   logic         all_released;
   logic [2:0]   rst_cause;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   reset_sequencer #(
      .NUM_DOMAINS     (N),
      .POR_CYCLES      (POR),
      .DEBOUNCE_CYCLES (DEB),
      .STAGGER_CYCLES  (STAG),
      .SW_PULSE_CYCLES (SW)
   ) dut (
      .clk_in       (clk),
      .rst_n        (rst_n),
      .ext_rst_in   (ext_rst_in),
      .sw_rst_req   (sw_rst_req),
      .cause_clr    (cause_clr),
      .rst_n_out    (rst_n_out),
      .all_released (all_released),
      .rst_cause    (rst_cause)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(input int c, input logic [2:0] o, input logic a,
                                input logic [2:0] ca, input string nm);
      exp_t e;
      e.cyc = c; e.out = o; e.al = a; e.cause = ca; e.name = nm;
      exp_q.push_back(e);
   endfunction

   // POR: release at iter 5 -> d0 +20, d1 +24, d2 +28, all_released +29
   task automatic test_reset();
      exp_t e;
      int   t0;
      t0 = cyc;
      push(t0 + 3,  3'b000, 1'b0, 3'b001, "reset_state");
      push(t0 + 24, 3'b000, 1'b0, 3'b001, "por_d0_early");
      push(t0 + 25, 3'b001, 1'b0, 3'b001, "por_d0");
      push(t0 + 28, 3'b001, 1'b0, 3'b001, "por_d1_early");
      push(t0 + 29, 3'b011, 1'b0, 3'b001, "por_d1");
      push(t0 + 32, 3'b011, 1'b0, 3'b001, "por_d2_early");
      push(t0 + 33, 3'b111, 1'b0, 3'b001, "por_d2");
      push(t0 + 34, 3'b111, 1'b1, 3'b001, "por_all_released");
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (rst_n_out !== e.out || all_released !== e.al || rst_cause !== e.cause) begin
               miscompares++;
               $display("FAIL %s @%0d: got out=%b all=%b cause=%b, want out=%b all=%b cause=%b",
                        e.name, cyc, rst_n_out, all_released, rst_cause, e.out, e.al, e.cause);
            end
         end
         if (k == 5) rst_n = 1'b1;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL test_reset: %0d expectations not reached, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Single sw pulse on domain 1: low 5 cycles, all_released drops, cause 101
   task automatic test_sw();
      exp_t e;
      int   t0;
      t0 = cyc;
      push(t0 + 1, 3'b111, 1'b1, 3'b001, "sw_idle");
      push(t0 + 2, 3'b101, 1'b1, 3'b101, "sw_low_first");
      push(t0 + 3, 3'b101, 1'b0, 3'b101, "sw_all_drop");
      push(t0 + 6, 3'b101, 1'b0, 3'b101, "sw_low_last");
      push(t0 + 7, 3'b111, 1'b0, 3'b101, "sw_release");
      push(t0 + 8, 3'b111, 1'b1, 3'b101, "sw_all_back");
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (rst_n_out !== e.out || all_released !== e.al || rst_cause !== e.cause) begin
               miscompares++;
               $display("FAIL %s @%0d: got out=%b all=%b cause=%b, want out=%b all=%b cause=%b",
                        e.name, cyc, rst_n_out, all_released, rst_cause, e.out, e.al, e.cause);
            end
         end
         sw_rst_req = (k == 1) ? 3'b010 : 3'b000;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL test_sw: %0d expectations not reached, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Repeat request after two low cycles: low 2 + 5 = 7 cycles in total
   task automatic test_sw_restart();
      exp_t e;
      int   t0;
      t0 = cyc;
      push(t0 + 2,  3'b101, 1'b1, 3'b101, "rs_low_first");
      push(t0 + 4,  3'b101, 1'b0, 3'b101, "rs_low_mid");
      push(t0 + 7,  3'b101, 1'b0, 3'b101, "rs_extended");
      push(t0 + 8,  3'b101, 1'b0, 3'b101, "rs_low_last");
      push(t0 + 9,  3'b111, 1'b0, 3'b101, "rs_release");
      push(t0 + 10, 3'b111, 1'b1, 3'b101, "rs_all_back");
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (rst_n_out !== e.out || all_released !== e.al || rst_cause !== e.cause) begin
               miscompares++;
               $display("FAIL %s @%0d: got out=%b all=%b cause=%b, want out=%b all=%b cause=%b",
                        e.name, cyc, rst_n_out, all_released, rst_cause, e.out, e.al, e.cause);
            end
         end
         sw_rst_req = (k == 1 || k == 3) ? 3'b010 : 3'b000;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL test_sw_restart: %0d expectations not reached, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Button pressed at iter 1: debounced edge seen during iter 11, outputs
   // low at +12. sw_rst_req=111 and cause_clr ride on that same cycle.
   // Release at iter 21 -> domain 0 back 30 cycles later.
   task automatic test_collision();
      exp_t e;
      int   t0;
      t0 = cyc;
      push(t0 + 11, 3'b111, 1'b1, 3'b101, "col_before_edge");
      push(t0 + 12, 3'b000, 1'b1, 3'b010, "col_all_low");
      push(t0 + 13, 3'b000, 1'b0, 3'b010, "col_all_drop");
      push(t0 + 50, 3'b000, 1'b0, 3'b010, "col_d0_early");
      push(t0 + 51, 3'b001, 1'b0, 3'b010, "col_d0");
      push(t0 + 55, 3'b011, 1'b0, 3'b010, "col_d1");
      push(t0 + 59, 3'b111, 1'b0, 3'b010, "col_d2");
      push(t0 + 60, 3'b111, 1'b1, 3'b010, "col_all_released");
      push(t0 + 70, 3'b111, 1'b1, 3'b010, "col_no_sw_left");
      for (int k = 1; k <= 72; k++) begin
         @(negedge clk);
         while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (rst_n_out !== e.out || all_released !== e.al || rst_cause !== e.cause) begin
               miscompares++;
               $display("FAIL %s @%0d: got out=%b all=%b cause=%b, want out=%b all=%b cause=%b",
                        e.name, cyc, rst_n_out, all_released, rst_cause, e.out, e.al, e.cause);
            end
         end
         if (k == 1)  ext_rst_in = 1'b1;
         if (k == 21) ext_rst_in = 1'b0;
         sw_rst_req = (k == 11) ? 3'b111 : 3'b000;
         cause_clr  = (k == 11);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL test_collision: %0d expectations not reached, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Glitches every 5 cycles must never reset. Steady press at iter 50 ->
   // outputs low at +61; release at iter 90 -> domain 0 back at +120.
   task automatic test_bounce();
      exp_t e;
      int   t0;
      t0 = cyc;
      push(t0 + 1, 3'b111, 1'b1, 3'b010, "bn_pre_clear");
      for (int c = 2; c <= 45; c++) push(t0 + c, 3'b111, 1'b1, 3'b000, "bn_glitch_ignored");
      push(t0 + 60,  3'b111, 1'b1, 3'b000, "bn_before_edge");
      push(t0 + 61,  3'b000, 1'b1, 3'b010, "bn_all_low");
      push(t0 + 62,  3'b000, 1'b0, 3'b010, "bn_all_drop");
      push(t0 + 119, 3'b000, 1'b0, 3'b010, "bn_d0_early");
      push(t0 + 120, 3'b001, 1'b0, 3'b010, "bn_d0");
      push(t0 + 123, 3'b001, 1'b0, 3'b010, "bn_d1_early");
      push(t0 + 124, 3'b011, 1'b0, 3'b010, "bn_d1");
      push(t0 + 127, 3'b011, 1'b0, 3'b010, "bn_d2_early");
      push(t0 + 128, 3'b111, 1'b0, 3'b010, "bn_d2");
      push(t0 + 129, 3'b111, 1'b1, 3'b010, "bn_all_released");
      for (int k = 1; k <= 132; k++) begin
         @(negedge clk);
         while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (rst_n_out !== e.out || all_released !== e.al || rst_cause !== e.cause) begin
               miscompares++;
               $display("FAIL %s @%0d: got out=%b all=%b cause=%b, want out=%b all=%b cause=%b",
                        e.name, cyc, rst_n_out, all_released, rst_cause, e.out, e.al, e.cause);
            end
         end
         cause_clr = (k == 1);
         if (k <= 41)     ext_rst_in = (k % 5 == 0);
         else if (k == 50) ext_rst_in = 1'b1;
         else if (k == 90) ext_rst_in = 1'b0;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL test_bounce: %0d expectations not reached, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Async reset while domain 1 is still held: outputs clear before any clock
   task automatic test_mid_release();
      exp_t e;
      int   t0;
      t0 = cyc;
      push(t0 + 24, 3'b001, 1'b0, 3'b001, "mr_partial");
      push(t0 + 46, 3'b000, 1'b0, 3'b001, "mr_d0_early");
      push(t0 + 47, 3'b001, 1'b0, 3'b001, "mr_d0");
      push(t0 + 51, 3'b011, 1'b0, 3'b001, "mr_d1");
      push(t0 + 55, 3'b111, 1'b0, 3'b001, "mr_d2");
      push(t0 + 56, 3'b111, 1'b1, 3'b001, "mr_all_released");
      push(t0 + 60, 3'b111, 1'b1, 3'b001, "mr_before_clr");
      push(t0 + 61, 3'b111, 1'b1, 3'b000, "mr_cause_cleared");
      for (int k = 1; k <= 63; k++) begin
         @(negedge clk);
         while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            vectors++;
            if (rst_n_out !== e.out || all_released !== e.al || rst_cause !== e.cause) begin
               miscompares++;
               $display("FAIL %s @%0d: got out=%b all=%b cause=%b, want out=%b all=%b cause=%b",
                        e.name, cyc, rst_n_out, all_released, rst_cause, e.out, e.al, e.cause);
            end
         end
         cause_clr = (k == 60);
         if (k == 3 || k == 27) rst_n = 1'b1;
         if (k == 1 || k == 25) begin
            rst_n = 1'b0;
            #1;
            vectors++;
            if (rst_n_out !== 3'b000 || all_released !== 1'b0 || rst_cause !== 3'b001) begin
               miscompares++;
               $display("FAIL mr_async_clear iter %0d: got out=%b all=%b cause=%b, want out=000 all=0 cause=001",
                        k, rst_n_out, all_released, rst_cause);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL test_mid_release: %0d expectations not reached, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst_n      = 1'b1;
      ext_rst_in = 1'b0;
      sw_rst_req = '0;
      cause_clr  = 1'b0;
      #1 rst_n   = 1'b0;
      test_reset();
      test_sw();
      test_sw_restart();
      test_collision();
      test_bounce();
      test_mid_release();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
